// File: rtl/mem_to_axi_manager.sv
// mem_to_axi_manager
//   Bridges an in-order memory request port (req/gnt, rvalid) onto an AXI4
//   manager port. Every request becomes one single-beat AXI transaction, with
//   ID 0. Responses return on the mem side strictly in grant order.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   mem_req_i/gnt_o     request handshake (req & gnt)
//   mem_addr_i/we_i     byte address, 1 = write
//   mem_wdata_i/strb_i  write data and byte enables
//   mem_rvalid_o        one pulse per granted request, in grant order
//   mem_rdata_o         read data (0 for write responses)
//   mem_err_o           SLVERR/DECERR flag, qualified by mem_rvalid_o
//   axi_req_o/rsp_i     AXI4 manager request/response structs

package mem_to_axi_pkg;
  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [0:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [0:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module mem_to_axi_manager #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         axi_req_t      = mem_to_axi_pkg::axi_req_t,
  parameter type         axi_rsp_t      = mem_to_axi_pkg::axi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [2:0]      AxSize  = 3'($clog2(StrbWidth));

  logic                 vld_p0, we_p0;
  logic [AddrWidth-1:0] addr_p0;
  logic [DataWidth-1:0] wdata_p0;
  logic [StrbWidth-1:0] strb_p0;
  logic                 aw_sent_q, w_sent_q;

  // Order FIFO: one bit per outstanding request, 1 = write.
  logic                 order_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;

  logic ar_valid, aw_valid, w_valid;
  logic ar_hs, aw_hs, w_hs, retire, grant;
  logic head_we, busy, r_ready, b_ready, r_hs, b_hs, resp_hs;
  logic unused_rsp;

  assign ar_valid = vld_p0 & ~we_p0;
  assign aw_valid = vld_p0 & we_p0 & ~aw_sent_q;
  assign w_valid  = vld_p0 & we_p0 & ~w_sent_q;

  assign ar_hs = ar_valid & axi_rsp_i.ar_ready;
  assign aw_hs = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid & axi_rsp_i.w_ready;

  // A write retires once both AW and W have been accepted, in any order.
  assign retire = ar_hs | (vld_p0 & we_p0 & (aw_sent_q | aw_hs) & (w_sent_q | w_hs));

  // The count term uses only the registered count, so a response never
  // opens a grant in the same cycle.
  assign grant     = rst_ni & mem_req_i & (~vld_p0 | retire) & (cnt_q < MaxCnt);
  assign mem_gnt_o = grant;

  // Only the channel at the FIFO head may deliver a response.
  assign busy    = (cnt_q != '0);
  assign head_we = order_q[rd_ptr_q];
  assign r_ready = busy & ~head_we;
  assign b_ready = busy & head_we;
  assign r_hs    = r_ready & axi_rsp_i.r_valid;
  assign b_hs    = b_ready & axi_rsp_i.b_valid;
  assign resp_hs = r_hs | b_hs;

  assign mem_rvalid_o = resp_hs;
  assign mem_rdata_o  = r_hs ? axi_rsp_i.r.data : '0;
  assign mem_err_o    = (r_hs & axi_rsp_i.r.resp[1]) | (b_hs & axi_rsp_i.b.resp[1]);

  assign unused_rsp = ^axi_rsp_i;

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.addr  = addr_p0;
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data   = wdata_p0;
    axi_req_o.w.strb   = strb_p0;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = b_ready;
    axi_req_o.ar.addr  = addr_p0;
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
  end

  // ---- stage p0: request register, issue flags, order FIFO control ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p0    <= 1'b0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (grant)       vld_p0 <= 1'b1;
      else if (retire) vld_p0 <= 1'b0;

      if (retire) begin
        aw_sent_q <= 1'b0;
        w_sent_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_sent_q <= 1'b1;
        if (w_hs)  w_sent_q  <= 1'b1;
      end

      if (grant)   wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (resp_hs) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;

      case ({grant, resp_hs})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      we_p0             <= mem_we_i;
      addr_p0           <= mem_addr_i;
      wdata_p0          <= mem_wdata_i;
      strb_p0           <= mem_strb_i;
      order_q[wr_ptr_q] <= mem_we_i;
    end
  end

endmodule

// File: tb/tb_mem_to_axi_manager.sv
module tb_mem_to_axi_manager;
  import mem_to_axi_pkg::*;

  localparam int MaxOut = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
  axi_req_t    axi_req;
  axi_rsp_t    axi_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_to_axi_manager #(
    .AddrWidth(32), .DataWidth(64), .MaxOutstanding(MaxOut),
    .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_addr_i(mem_addr),
    .mem_we_i(mem_we), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
    .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata), .mem_err_o(mem_err),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] sdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } txn_t;

  vec_t        vecs [6];
  txn_t        exp_rsp_q [$];
  logic [31:0] exp_ar_q [$];
  logic [31:0] exp_aw_q [$];
  logic [71:0] exp_w_q [$];
  logic [31:0] sub_r_q [$];
  logic [31:0] sub_aw_q [$];
  logic [31:0] sub_b_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // Subordinate behaviour used by the random phase: data and response code
  // are pure functions of the address.
  function automatic logic [63:0] sub_data(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [1:0] sub_resp(input logic [31:0] a);
    return a[5:4];
  endfunction

  task automatic run_vec(input vec_t v);
    mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
    mem_wdata = v.wdata; mem_strb = v.strb;
    #1 chk("vec_gnt", mem_gnt, 1);
    tick();
    mem_req = 1'b0;
    axi_rsp.ar_ready = 1'b1; axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    #1;
    if (!v.we) begin
      chk("vec_ar_valid", axi_req.ar_valid, 1);
      chk("vec_ar_addr", axi_req.ar.addr, v.addr);
      chk("vec_ar_size", axi_req.ar.size, 3);
      chk("vec_ar_len", axi_req.ar.len, 0);
      chk("vec_ar_burst", axi_req.ar.burst, 1);
      chk("vec_aw_idle", axi_req.aw_valid, 0);
    end else begin
      chk("vec_aw_valid", axi_req.aw_valid, 1);
      chk("vec_w_valid", axi_req.w_valid, 1);
      chk("vec_aw_addr", axi_req.aw.addr, v.addr);
      chk("vec_aw_size", axi_req.aw.size, 3);
      chk("vec_w_data", axi_req.w.data, v.wdata);
      chk("vec_w_strb", axi_req.w.strb, v.strb);
      chk("vec_w_last", axi_req.w.last, 1);
      chk("vec_ar_idle", axi_req.ar_valid, 0);
    end
    tick();
    axi_rsp.ar_ready = 1'b0; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
    #1;
    chk("vec_retired", axi_req.ar_valid | axi_req.aw_valid | axi_req.w_valid, 0);
    chk("vec_no_early_rvalid", mem_rvalid, 0);
    tick();
    tick();
    if (!v.we) begin
      axi_rsp.r_valid = 1'b1; axi_rsp.r.data = v.sdata; axi_rsp.r.resp = v.resp;
    end else begin
      axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = v.resp;
    end
    #1;
    chk("vec_rvalid", mem_rvalid, 1);
    chk("vec_rdata", mem_rdata, v.exp_rdata);
    chk("vec_err", mem_err, v.exp_err);
    tick();
    axi_rsp.r_valid = 1'b0; axi_rsp.b_valid = 1'b0;
    #1;
    chk("vec_rvalid_off", mem_rvalid, 0);
    chk("vec_fifo_empty", axi_req.r_ready | axi_req.b_ready, 0);
  endtask

  initial begin
    txn_t        t;
    logic [71:0] wexp;
    logic [1:0]  rr;
    logic        r_act, b_act;
    int          sub_w_cnt, ngrant, nresp;

    vecs[0] = '{1'b0, 32'h100, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF, 1'b0, 64'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h108, 64'h0, 8'h00, 2'b10, 64'h55, 1'b1, 64'h55};
    vecs[2] = '{1'b1, 32'h40, 64'h1234, 8'h0F, 2'b00, 64'h0, 1'b0, 64'h0};
    vecs[3] = '{1'b1, 32'h48, 64'hFFFF_0000_1111_2222, 8'h00, 2'b11, 64'h0, 1'b1, 64'h0};
    vecs[4] = '{1'b0, 32'hABC0, 64'h0, 8'h00, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{1'b1, 32'h7F8, 64'hCAFE, 8'hF0, 2'b10, 64'h0, 1'b1, 64'h0};

    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_strb = '0; axi_rsp = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_gnt", mem_gnt, 0);
    chk("rst_rvalid", mem_rvalid, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}, 0);
    chk("rst_readies", {axi_req.b_ready, axi_req.r_ready}, 0);
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Write whose W is accepted two cycles after AW, followed by a read
    // whose R arrives before the write's B.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 64'h1234; mem_strb = 8'h0F;
    #1 chk("wr_gnt", mem_gnt, 1);
    tick();
    mem_we = 1'b0; mem_addr = 32'h80; axi_rsp.aw_ready = 1'b1;
    #1;
    chk("wr_c1_aw", axi_req.aw_valid, 1);
    chk("wr_c1_w", axi_req.w_valid, 1);
    chk("wr_c1_gnt", mem_gnt, 0);
    tick();
    axi_rsp.aw_ready = 1'b0;
    #1;
    chk("wr_c2_aw_done", axi_req.aw_valid, 0);
    chk("wr_c2_w_held", axi_req.w_valid, 1);
    chk("wr_c2_gnt", mem_gnt, 0);
    tick();
    axi_rsp.w_ready = 1'b1;
    #1;
    chk("wr_c3_w", axi_req.w_valid, 1);
    chk("wr_c3_gnt", mem_gnt, 1);
    tick();
    mem_req = 1'b0; axi_rsp.w_ready = 1'b0; axi_rsp.ar_ready = 1'b1;
    #1;
    chk("wr_c4_w_idle", axi_req.w_valid | axi_req.aw_valid, 0);
    chk("wr_c4_ar", axi_req.ar_valid, 1);
    chk("wr_c4_ar_addr", axi_req.ar.addr, 32'h80);
    chk("wr_c4_b_ready", axi_req.b_ready, 1);
    chk("wr_c4_r_ready", axi_req.r_ready, 0);
    tick();
    axi_rsp.ar_ready = 1'b0; axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'hAA; axi_rsp.r.resp = 2'b00;
    #1;
    chk("ord_r_held", axi_req.r_ready, 0);
    chk("ord_no_rvalid", mem_rvalid, 0);
    tick();
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = 2'b00;
    #1;
    chk("ord_b_rvalid", mem_rvalid, 1);
    chk("ord_b_rdata", mem_rdata, 0);
    chk("ord_b_err", mem_err, 0);
    tick();
    axi_rsp.b_valid = 1'b0;
    #1;
    chk("ord_r_ready", axi_req.r_ready, 1);
    chk("ord_r_rvalid", mem_rvalid, 1);
    chk("ord_r_rdata", mem_rdata, 64'hAA);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1 chk("ord_done", mem_rvalid, 0);

    // Outstanding limit with a subordinate that never responds.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; axi_rsp.ar_ready = 1'b1;
    ngrant = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (mem_gnt) ngrant++;
      tick();
    end
    chk("max_grants", ngrant, MaxOut);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h1; axi_rsp.r.resp = 2'b00;
    #1;
    chk("max_resp", mem_rvalid, 1);
    chk("max_no_same_cycle_gnt", mem_gnt, 0);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1 chk("max_next_cycle_gnt", mem_gnt, 1);
    tick();
    mem_req = 1'b0; axi_rsp.r_valid = 1'b1;
    tick();
    tick();
    axi_rsp.r_valid = 1'b0; axi_rsp.ar_ready = 1'b0; mem_req = 1'b1;
    #1 chk("pre_rst_gnt", mem_gnt, 1);
    tick();
    mem_req = 1'b0;
    #1 chk("pre_rst_stage", axi_req.ar_valid, 1);

    // Reset with three outstanding and the stage full.
    rst_n = 1'b0; mem_req = 1'b1;
    tick();
    #1;
    chk("mid_rst_gnt", mem_gnt, 0);
    chk("mid_rst_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}, 0);
    chk("mid_rst_readies", {axi_req.b_ready, axi_req.r_ready}, 0);
    chk("mid_rst_rvalid", mem_rvalid, 0);
    tick();
    rst_n = 1'b1; mem_addr = 32'h200; axi_rsp.ar_ready = 1'b1;
    #1 chk("post_rst_gnt", mem_gnt, 1);
    tick();
    mem_req = 1'b0;
    #1;
    chk("post_rst_ar", axi_req.ar_valid, 1);
    chk("post_rst_ar_addr", axi_req.ar.addr, 32'h200);
    chk("post_rst_r_ready", axi_req.r_ready, 1);
    tick();
    axi_rsp.ar_ready = 1'b0; axi_rsp.r_valid = 1'b1; axi_rsp.r.data = 64'h77;
    #1;
    chk("post_rst_rvalid", mem_rvalid, 1);
    chk("post_rst_rdata", mem_rdata, 64'h77);
    tick();
    axi_rsp.r_valid = 1'b0;
    #1 chk("post_rst_empty", axi_req.r_ready, 0);
    tick();

    // Random traffic against a reference subordinate and in-order model.
    axi_rsp = '0; r_act = 1'b0; b_act = 1'b0; sub_w_cnt = 0; nresp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mem_req   = (cyc < 2500) && ($urandom_range(0, 3) != 0);
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = $urandom;
      mem_addr[2:0] = 3'b000;
      mem_wdata = {$urandom, $urandom};
      mem_strb  = 8'($urandom);
      axi_rsp.ar_ready = 1'($urandom_range(0, 1));
      axi_rsp.aw_ready = 1'($urandom_range(0, 1));
      axi_rsp.w_ready  = 1'($urandom_range(0, 1));
      if (!r_act && sub_r_q.size() > 0 && $urandom_range(0, 1) == 1) r_act = 1'b1;
      if (!b_act && sub_b_q.size() > 0 && $urandom_range(0, 1) == 1) b_act = 1'b1;
      axi_rsp.r_valid = r_act;
      axi_rsp.b_valid = b_act;
      if (r_act) begin
        axi_rsp.r.data = sub_data(sub_r_q[0]);
        axi_rsp.r.resp = sub_resp(sub_r_q[0]);
      end
      if (b_act) axi_rsp.b.resp = sub_resp(sub_b_q[0]);
      #1;
      if (mem_gnt) begin
        chk("rnd_cap", exp_rsp_q.size() < MaxOut, 1);
        t = '{mem_we, mem_addr, mem_wdata, mem_strb};
        exp_rsp_q.push_back(t);
        if (mem_we) begin
          exp_aw_q.push_back(mem_addr);
          exp_w_q.push_back({mem_strb, mem_wdata});
        end else begin
          exp_ar_q.push_back(mem_addr);
        end
      end
      if (axi_req.ar_valid && axi_rsp.ar_ready) begin
        if (exp_ar_q.size() == 0) fail_now("rnd_ar_spurious");
        else chk("rnd_ar_addr", axi_req.ar.addr, exp_ar_q.pop_front());
        sub_r_q.push_back(axi_req.ar.addr);
      end
      if (axi_req.aw_valid && axi_rsp.aw_ready) begin
        if (exp_aw_q.size() == 0) fail_now("rnd_aw_spurious");
        else chk("rnd_aw_addr", axi_req.aw.addr, exp_aw_q.pop_front());
        sub_aw_q.push_back(axi_req.aw.addr);
      end
      if (axi_req.w_valid && axi_rsp.w_ready) begin
        if (exp_w_q.size() == 0) fail_now("rnd_w_spurious");
        else begin
          wexp = exp_w_q.pop_front();
          chk("rnd_w_data", axi_req.w.data, wexp[63:0]);
          chk("rnd_w_strb", axi_req.w.strb, wexp[71:64]);
        end
        sub_w_cnt++;
      end
      if (mem_rvalid) begin
        nresp++;
        if (exp_rsp_q.size() == 0) fail_now("rnd_rvalid_spurious");
        else begin
          t  = exp_rsp_q.pop_front();
          rr = sub_resp(t.addr);
          chk("rnd_rdata", mem_rdata, t.we ? 64'h0 : sub_data(t.addr));
          chk("rnd_err", mem_err, rr[1]);
        end
      end
      if (r_act && axi_req.r_ready) begin
        void'(sub_r_q.pop_front());
        r_act = 1'b0;
      end
      if (b_act && axi_req.b_ready) begin
        void'(sub_b_q.pop_front());
        b_act = 1'b0;
      end
      while (sub_aw_q.size() > 0 && sub_w_cnt > 0) begin
        sub_b_q.push_back(sub_aw_q.pop_front());
        sub_w_cnt--;
      end
      tick();
    end
    chk("rnd_drained", exp_rsp_q.size(), 0);
    chk("rnd_activity", nresp > 200, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
